// File: rtl/dpll_pkg.sv
// Shared DPLL definitions: default K-counter widths, phase-error direction
// encoding and the modulus clamp used wherever k_sel is consumed.
package dpll_pkg;

  localparam int K_MAX_DEF = 8;
  localparam int K_MIN_DEF = 3;

  localparam logic DIR_LEAD = 1'b1;
  localparam logic DIR_LAG  = 1'b0;

  function automatic logic [3:0] clamp_k(input logic [3:0] k_sel,
                                         input logic [3:0] k_min,
                                         input logic [3:0] k_max);
    if (k_sel < k_min)
      return k_min;
    else if (k_sel > k_max)
      return k_max;
    else
      return k_sel;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer with asynchronous active-low reset; output resets to 0.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/k_counter_filter.sv
// DPLL K-counter loop filter: two modulo-2^k_q counters, one per error direction.
// Optional lock detector built when LOCK_DETECT_EN is defined.
module k_counter_filter
  import dpll_pkg::*;
#(
  parameter int K_MAX       = K_MAX_DEF,
  parameter int K_MIN       = K_MIN_DEF,
  parameter int LOCK_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       dir,
  input  logic [3:0] k_sel,
  output logic       carry,
  output logic       borrow,
  output logic       lock
);

  localparam logic [K_MAX-1:0] ONE = K_MAX'(1);

  if (K_MIN < 1 || K_MIN > K_MAX || K_MAX > 15 || LOCK_CYCLES < 1) begin : g_bad_param
    $error("k_counter_filter: illegal parameter combination");
  end

  logic             dir_s;
  logic [3:0]       k_q;
  logic [K_MAX-1:0] up_cnt;
  logic [K_MAX-1:0] dn_cnt;
  logic [K_MAX:0]   m_val;
  logic [K_MAX-1:0] term;
  logic             up_hit;
  logic             dn_hit;

  sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (dir),
    .q   (dir_s)
  );

  // M = 2^k_q; at k_q = K_MAX the low K_MAX bits are 0 and term becomes all ones
  assign m_val  = {{K_MAX{1'b0}}, 1'b1} << k_q;
  assign term   = m_val[K_MAX-1:0] - ONE;
  assign up_hit = en && (dir_s == DIR_LEAD) && (up_cnt >= term);
  assign dn_hit = en && (dir_s == DIR_LAG)  && (dn_cnt >= term);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_q    <= 4'(K_MIN);
      up_cnt <= '0;
      dn_cnt <= '0;
      carry  <= 1'b0;
      borrow <= 1'b0;
    end else begin
      k_q    <= clamp_k(k_sel, 4'(K_MIN), 4'(K_MAX));
      carry  <= up_hit;
      borrow <= dn_hit;
      if (en) begin
        if (dir_s == DIR_LEAD)
          up_cnt <= up_hit ? '0 : up_cnt + ONE;
        else
          dn_cnt <= dn_hit ? '0 : dn_cnt + ONE;
      end
    end
  end

`ifdef LOCK_DETECT_EN
  localparam int QW = $clog2(LOCK_CYCLES + 1);

  logic [QW-1:0] quiet_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quiet_cnt <= '0;
      lock      <= 1'b0;
    end else begin
      lock <= (quiet_cnt >= QW'(LOCK_CYCLES));
      if (up_hit || dn_hit)
        quiet_cnt <= '0;
      else if (en && (quiet_cnt < QW'(LOCK_CYCLES)))
        quiet_cnt <= quiet_cnt + QW'(1);
    end
  end
`else
  assign lock = 1'b0;
`endif

endmodule

// File: tb/tb_k_counter_filter.sv
// Directed bench for k_counter_filter: pulse timing per modulus, clamping,
// per-direction retention, enable freeze, async reset and the optional lock flag.
module tb_k_counter_filter;

`ifdef LOCK_DETECT_EN
  localparam bit LOCK_ON = 1'b1;
`else
  localparam bit LOCK_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       dir = 1'b0;
  logic [3:0] k_sel = 4'd3;
  logic       carry;
  logic       borrow;
  logic       lock;

  int vec_cnt = 0;
  int err_cnt = 0;

  k_counter_filter #(.LOCK_CYCLES(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .dir    (dir),
    .k_sel  (k_sel),
    .carry  (carry),
    .borrow (borrow),
    .lock   (lock)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset with en low, then release; the next edge is step 1.
  task automatic restart(input logic [3:0] k, input logic d, input logic e);
    step();
    rst = 1'b0;
    en = 1'b0;
    dir = d;
    k_sel = k;
    step();
    step();
    rst = 1'b1;
    en = e;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    vec_cnt++;
    if ({carry, borrow, lock} !== 3'b000) begin
      err_cnt++;
      $display("FAIL reset_outputs: got c/b/l=%b%b%b want 000", carry, borrow, lock);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_c;
    restart(4'd3, 1'b1, 1'b1);
    for (int k = 1; k <= 26; k++) begin
      step();
      exp_c = (k == 10) || (k == 18) || (k == 26);
      vec_cnt++;
      if ({carry, borrow} !== {exp_c, 1'b0}) begin
        err_cnt++;
        $display("FAIL m8_carry step %0d: got c/b=%b%b want %b0", k, carry, borrow, exp_c);
      end
    end
  endtask

  task automatic test_clamp_low();
    logic exp_b;
    restart(4'd0, 1'b0, 1'b1);
    for (int k = 1; k <= 24; k++) begin
      step();
      exp_b = (k == 8) || (k == 16) || (k == 24);
      vec_cnt++;
      if ({carry, borrow} !== {1'b0, exp_b}) begin
        err_cnt++;
        $display("FAIL clamp_low step %0d: got c/b=%b%b want 0%b", k, carry, borrow, exp_b);
      end
    end
  endtask

  task automatic test_clamp_high();
    logic exp_b;
    restart(4'd15, 1'b0, 1'b1);
    for (int k = 1; k <= 260; k++) begin
      step();
      exp_b = (k == 256);
      vec_cnt++;
      if ({carry, borrow} !== {1'b0, exp_b}) begin
        err_cnt++;
        $display("FAIL clamp_high step %0d: got c/b=%b%b want 0%b", k, carry, borrow, exp_b);
      end
    end
  endtask

  task automatic test_retention();
    logic exp_c, exp_b;
    restart(4'd4, 1'b1, 1'b0);
    step();
    step();
    en = 1'b1;
    for (int k = 1; k <= 36; k++) begin
      step();
      exp_c = (k == 32);
      exp_b = (k == 26);
      vec_cnt++;
      if ({carry, borrow} !== {exp_c, exp_b}) begin
        err_cnt++;
        $display("FAIL retention step %0d: got c/b=%b%b want %b%b", k, carry, borrow, exp_c, exp_b);
      end
      if (k == 8) dir = 1'b0;
      if (k == 24) dir = 1'b1;
    end
  endtask

  task automatic test_shrink();
    logic exp_c;
    restart(4'd4, 1'b1, 1'b0);
    step();
    step();
    en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      exp_c = (k == 14);
      vec_cnt++;
      if ({carry, borrow} !== {exp_c, 1'b0}) begin
        err_cnt++;
        $display("FAIL shrink step %0d: got c/b=%b%b want %b0", k, carry, borrow, exp_c);
      end
      if (k == 12) begin
        k_sel = 4'd3;
        en = 1'b0;
      end
      if (k == 13) en = 1'b1;
    end
  endtask

  task automatic test_freeze();
    logic exp_b;
    restart(4'd3, 1'b0, 1'b1);
    for (int k = 1; k <= 37; k++) begin
      step();
      exp_b = (k == 28) || (k == 36);
      vec_cnt++;
      if ({carry, borrow} !== {1'b0, exp_b}) begin
        err_cnt++;
        $display("FAIL freeze step %0d: got c/b=%b%b want 0%b", k, carry, borrow, exp_b);
      end
      if (k == 5) en = 1'b0;
      if (k == 25) en = 1'b1;
      if (k == 36) en = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic exp_c;
    restart(4'd3, 1'b1, 1'b1);
    for (int k = 1; k <= 10; k++) step();
    vec_cnt++;
    if (carry !== 1'b1) begin
      err_cnt++;
      $display("FAIL pre_reset_carry: got %b want 1", carry);
    end
    rst = 1'b0;
    #1;
    vec_cnt++;
    if ({carry, borrow, lock} !== 3'b000) begin
      err_cnt++;
      $display("FAIL async_reset: got c/b/l=%b%b%b want 000", carry, borrow, lock);
    end
    step();
    rst = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      exp_c = (k == 10);
      vec_cnt++;
      if ({carry, borrow} !== {exp_c, 1'b0}) begin
        err_cnt++;
        $display("FAIL restart_carry step %0d: got c/b=%b%b want %b0", k, carry, borrow, exp_c);
      end
    end
  endtask

  task automatic test_lock();
    logic exp_c, exp_l;
    restart(4'd5, 1'b1, 1'b1);
    for (int k = 1; k <= 36; k++) begin
      step();
      exp_c = (k == 34);
      exp_l = LOCK_ON && (k >= 17) && (k <= 34);
      vec_cnt++;
      if ({carry, borrow, lock} !== {exp_c, 1'b0, exp_l}) begin
        err_cnt++;
        $display("FAIL lock step %0d: got c/b/l=%b%b%b want %b0%b",
                 k, carry, borrow, lock, exp_c, exp_l);
      end
    end
  endtask

  initial begin
    test_reset();
    step();
    rst = 1'b1;
    test_back_to_back();
    test_clamp_low();
    test_clamp_high();
    test_retention();
    test_shrink();
    test_freeze();
    test_reset_mid();
    test_lock();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
